// File: rtl/ifu_prefetch.sv
// Instruction fetch/prefetch stage: word reads into a small FIFO, instruction+immediate assembly.
// Optional feature macro IFU_PERF_CNT_EN adds fetch/stall performance counters.
module ifu_prefetch #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16,
  parameter int OP_W   = 4,
  parameter int QDEPTH = 4,
  parameter logic [OP_W-1:0] OP_LDI = 4'h1,
  parameter logic [OP_W-1:0] OP_STI = 4'h2,
  parameter logic [OP_W-1:0] OP_HLT = 4'hE
) (
  input  logic              Global_clk,
  input  logic              Global_rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [WORD_W-1:0] ins_word,
  output logic [WORD_W-1:0] ins_imm,
  output logic              ins_has_imm,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int PTR_W = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] PC_TWO   = ADDR_W'(2'd2);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_TWO  = CNT_W'(2'd2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: OP_W];
  endfunction

  function automatic logic needs_imm(input logic [WORD_W-1:0] w);
    logic [OP_W-1:0] op;
    op = opcode_of(w);
    return (op[OP_W-1] & op[0]) | (op == OP_LDI) | (op == OP_STI);
  endfunction

  state_t              state_r;
  logic                mem_req_r;
  logic [ADDR_W-1:0]   fetch_pc_r;
  logic                expect_imm_r;
  logic [WORD_W-1:0]   fifo_r [QDEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   asm_pc_r;
  logic                ins_valid_r;
  logic [WORD_W-1:0]   ins_word_r;
  logic [WORD_W-1:0]   ins_imm_r;
  logic                ins_has_imm_r;
  logic [ADDR_W-1:0]   ins_pc_r;
  logic                halted_r;

  logic                ack_take_s;
  logic                hlt_ack_s;
  logic [WORD_W-1:0]   head_s;
  logic [WORD_W-1:0]   second_s;
  logic                pop1_s;
  logic                pop2_s;
  logic [CNT_W-1:0]    pop_cnt_s;
  logic [CNT_W-1:0]    cnt_next_s;
  logic                hs_s;
  logic                hs_hlt_s;

  // Fetch acceptance, assembler pop decision and next FIFO occupancy
  always_comb begin
    ack_take_s = 1'b0;
    hlt_ack_s  = 1'b0;
    pop1_s     = 1'b0;
    pop2_s     = 1'b0;
    pop_cnt_s  = '0;
    head_s     = fifo_r[rd_ptr_r];
    second_s   = fifo_r[rd_ptr_r + PTR_ONE];
    hs_s       = ins_valid_r & ins_ready;
    hs_hlt_s   = hs_s & ~ins_has_imm_r & (opcode_of(ins_word_r) == OP_HLT);
    // A word acked in the flush cycle is dropped; a word following an immediate opcode is never decoded
    if (mem_req_r && mem_ack && !flush && (state_r == ST_REQ)) begin
      ack_take_s = 1'b1;
      hlt_ack_s  = ~expect_imm_r & (opcode_of(mem_rdata) == OP_HLT);
    end else begin
      ack_take_s = 1'b0;
      hlt_ack_s  = 1'b0;
    end
    if (!ins_valid_r || ins_ready) begin
      if (needs_imm(head_s)) begin
        if (cnt_r >= CNT_TWO) begin
          pop2_s    = 1'b1;
          pop_cnt_s = CNT_TWO;
        end else begin
          pop2_s    = 1'b0;
        end
      end else if (cnt_r >= CNT_ONE) begin
        pop1_s    = 1'b1;
        pop_cnt_s = CNT_ONE;
      end else begin
        pop1_s    = 1'b0;
      end
    end else begin
      pop_cnt_s = '0;
    end
    cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, ack_take_s} - pop_cnt_s;
  end

  // Fetch FSM: request issue, fetch PC and immediate tracking
  always_ff @(posedge Global_clk or negedge Global_rst_n) begin
    if (!Global_rst_n) begin
      state_r      <= ST_IDLE;
      mem_req_r    <= 1'b0;
      fetch_pc_r   <= '0;
      expect_imm_r <= 1'b0;
    end else if (flush) begin
      state_r      <= ST_REQ;
      mem_req_r    <= 1'b0;
      fetch_pc_r   <= flush_pc;
      expect_imm_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_REQ;
            mem_req_r    <= 1'b1;
            fetch_pc_r   <= start_pc;
            expect_imm_r <= 1'b0;
          end else begin
            mem_req_r    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_take_s) begin
            fetch_pc_r   <= fetch_pc_r + PC_ONE;
            expect_imm_r <= ~expect_imm_r & needs_imm(mem_rdata);
          end
          if (hlt_ack_s) begin
            state_r   <= ST_STOP;
            mem_req_r <= 1'b0;
          end else begin
            mem_req_r <= (cnt_next_s < CNT_FULL);
          end
        end
        ST_STOP: begin
          mem_req_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO storage and pointers
  always_ff @(posedge Global_clk or negedge Global_rst_n) begin
    if (!Global_rst_n) begin
      for (int i = 0; i < QDEPTH; i++) fifo_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (ack_take_s) begin
        fifo_r[wr_ptr_r] <= mem_rdata;
        wr_ptr_r         <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_r + pop_cnt_s[PTR_W-1:0];
      cnt_r    <= cnt_next_s;
    end
  end

  // Assembler output register and its own PC copy
  always_ff @(posedge Global_clk or negedge Global_rst_n) begin
    if (!Global_rst_n) begin
      asm_pc_r      <= '0;
      ins_valid_r   <= 1'b0;
      ins_word_r    <= '0;
      ins_imm_r     <= '0;
      ins_has_imm_r <= 1'b0;
      ins_pc_r      <= '0;
    end else if (flush) begin
      asm_pc_r      <= flush_pc;
      ins_valid_r   <= 1'b0;
      ins_word_r    <= '0;
      ins_imm_r     <= '0;
      ins_has_imm_r <= 1'b0;
      ins_pc_r      <= '0;
    end else if (start && (state_r == ST_IDLE)) begin
      asm_pc_r      <= start_pc;
    end else if (pop1_s || pop2_s) begin
      ins_valid_r   <= 1'b1;
      ins_word_r    <= head_s;
      ins_imm_r     <= pop2_s ? second_s : '0;
      ins_has_imm_r <= pop2_s;
      ins_pc_r      <= asm_pc_r;
      asm_pc_r      <= asm_pc_r + (pop2_s ? PC_TWO : PC_ONE);
    end else if (hs_s) begin
      ins_valid_r   <= 1'b0;
    end else begin
      ins_valid_r   <= ins_valid_r;
    end
  end

  // Halt status: set when HLT is handed over, cleared by a restart
  always_ff @(posedge Global_clk or negedge Global_rst_n) begin
    if (!Global_rst_n) begin
      halted_r <= 1'b0;
    end else if (flush || start) begin
      halted_r <= 1'b0;
    end else if (hs_hlt_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = fetch_pc_r;
  assign ins_valid   = ins_valid_r;
  assign ins_word    = ins_word_r;
  assign ins_imm     = ins_imm_r;
  assign ins_has_imm = ins_has_imm_r;
  assign ins_pc      = ins_pc_r;
  assign halted      = halted_r;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_r;
  logic [31:0] perf_stall_cnt_r;

  // Saturating fetch and stall counters
  always_ff @(posedge Global_clk or negedge Global_rst_n) begin
    if (!Global_rst_n) begin
      perf_fetch_cnt_r <= 32'd0;
      perf_stall_cnt_r <= 32'd0;
    end else if (start) begin
      perf_fetch_cnt_r <= 32'd0;
      perf_stall_cnt_r <= 32'd0;
    end else begin
      if (ack_take_s && (perf_fetch_cnt_r != 32'hFFFF_FFFF))
        perf_fetch_cnt_r <= perf_fetch_cnt_r + 32'd1;
      if (ins_valid_r && !ins_ready && (perf_stall_cnt_r != 32'hFFFF_FFFF))
        perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_r;
  assign perf_stall_cnt = perf_stall_cnt_r;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: random programs and memory/execute timing against a
// program-walk reference model of the expected instruction stream.
module tb_ifu_prefetch;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 16;
  localparam int QDEPTH = 4;
  localparam logic [3:0] LDI = 4'h1;
  localparam logic [3:0] STI = 4'h2;
  localparam logic [3:0] HLT = 4'hE;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] imm;
    logic        has;
    logic [7:0]  pc;
  } ins_t;

  logic              Global_clk;
  logic              Global_rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              ins_valid;
  logic              ins_ready;
  logic [WORD_W-1:0] ins_word;
  logic [WORD_W-1:0] ins_imm;
  logic              ins_has_imm;
  logic [ADDR_W-1:0] ins_pc;
  logic              halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]       perf_fetch_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  ifu_prefetch dut (
    .Global_clk   (Global_clk),
    .Global_rst_n (Global_rst_n),
    .start        (start),
    .start_pc     (start_pc),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins_word     (ins_word),
    .ins_imm      (ins_imm),
    .ins_has_imm  (ins_has_imm),
    .ins_pc       (ins_pc),
    .halted       (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [15:0] mem [256];
  ins_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode = 0;
  int          ack_pct    = 100;
  int          acks       = 0;
  int          extra_ins  = 0;
  bit          flush_pend = 1'b0;
  bit          chk_flush_gap = 1'b0;

  initial Global_clk = 1'b0;
  always #5 Global_clk = ~Global_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_needs_imm(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    return (op[3] & op[0]) | (op == LDI) | (op == STI);
  endfunction

  // Reference: walk the program from pc, pairing immediates, ending at the first HLT instruction
  task automatic build_exp(input logic [7:0] sp);
    logic [7:0] pc;
    logic [7:0] nx;
    ins_t       e;
    exp_q.delete();
    pc = sp;
    for (int i = 0; i < 128; i++) begin
      e.pc   = pc;
      e.word = mem[pc];
      nx     = pc + 8'd1;
      if (m_needs_imm(e.word)) begin
        e.has = 1'b1;
        e.imm = mem[nx];
        pc    = pc + 8'd2;
      end else begin
        e.has = 1'b0;
        e.imm = 16'h0000;
        pc    = nx;
      end
      exp_q.push_back(e);
      if (!e.has && (e.word[15:12] == HLT)) break;
    end
  endtask

  task automatic gen_prog(input logic [7:0] sp, input int n);
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [15:0] w;
    pc = sp;
    for (int i = 0; i < n; i++) begin
      do op = 4'($urandom_range(15)); while (op == HLT);
      w = {op, 12'($urandom)};
      mem[pc] = w;
      pc = pc + 8'd1;
      if (m_needs_imm(w)) begin
        mem[pc] = ($urandom_range(3) == 0) ? 16'hE000 : 16'($urandom);
        pc = pc + 8'd1;
      end
    end
    mem[pc] = {HLT, 12'($urandom)};
  endtask

  // Execute-stage and memory model: drives ready/ack/flush, scoreboards handshakes
  initial begin
    ins_t e;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    ins_ready = 1'b0;
    flush     = 1'b0;
    forever begin
      @(negedge Global_clk);
      flush = 1'b0;
      if (chk_flush_gap) begin
        check("valid_after_flush", 32'(ins_valid), 32'd0);
        chk_flush_gap = 1'b0;
      end
      case (ready_mode)
        0:       ins_ready = 1'b1;
        1:       ins_ready = 1'($urandom_range(1));
        default: ins_ready = 1'b0;
      endcase
      if (ins_valid && ins_ready) begin
        if (exp_q.size() == 0) begin
          extra_ins++;
        end else begin
          e = exp_q.pop_front();
          check("ins_pc",      32'(ins_pc),      32'(e.pc));
          check("ins_word",    32'(ins_word),    32'(e.word));
          check("ins_imm",     32'(ins_imm),     32'(e.imm));
          check("ins_has_imm", 32'(ins_has_imm), 32'(e.has));
        end
      end
      if (mem_req && ($urandom_range(99) < ack_pct)) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        acks++;
        if (flush_pend) begin
          flush         = 1'b1;
          flush_pend    = 1'b0;
          chk_flush_gap = 1'b1;
          build_exp(flush_pc);
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end
  end

  task automatic do_reset();
    Global_rst_n = 1'b0;
    @(negedge Global_clk);
    @(negedge Global_clk);
    Global_rst_n = 1'b1;
    exp_q.delete();
    extra_ins = 0;
    acks = 0;
    @(negedge Global_clk);
  endtask

  task automatic pulse_start(input logic [7:0] sp);
    start_pc = sp;
    start = 1'b1;
    @(negedge Global_clk);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int k;
    int req_seen;
    k = 0;
    while (!halted && (k < budget)) begin
      @(negedge Global_clk);
      k++;
    end
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_extra"}, 32'(extra_ins), 32'd0);
    req_seen = 0;
    repeat (6) begin
      @(negedge Global_clk);
      if (mem_req) req_seen++;
    end
    check({tag, "_req_after_halt"}, 32'(req_seen), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mem_req"},     32'(mem_req),     32'd0);
    check({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
    check({tag, "_ins_valid"},   32'(ins_valid),   32'd0);
    check({tag, "_ins_word"},    32'(ins_word),    32'd0);
    check({tag, "_ins_imm"},     32'(ins_imm),     32'd0);
    check({tag, "_ins_has_imm"}, 32'(ins_has_imm), 32'd0);
    check({tag, "_ins_pc"},      32'(ins_pc),      32'd0);
    check({tag, "_halted"},      32'(halted),      32'd0);
  endtask

  initial begin
    int k;
    int diffs;
    bit snap_ok;
    logic [15:0] s_word;
    logic [15:0] s_imm;
    logic        s_has;
    logic [7:0]  s_pc;
    int exp_acks;

    Global_rst_n = 1'b0;
    start = 1'b0;
    start_pc = 8'h00;
    flush_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    @(negedge Global_clk);
    @(negedge Global_clk);
    check_zero_outputs("reset");
    Global_rst_n = 1'b1;
    @(negedge Global_clk);

    // Directed program with first-instruction latency checks
    mem[0] = 16'h8123; mem[1] = 16'h9120; mem[2] = 16'h0005; mem[3] = 16'hE000;
    build_exp(8'h00);
    ready_mode = 0; ack_pct = 100;
    pulse_start(8'h00);
    check("req_after_start", 32'(mem_req), 32'd1);
    check("valid_n1", 32'(ins_valid), 32'd0);
    @(negedge Global_clk);
    check("valid_n2", 32'(ins_valid), 32'd0);
    @(negedge Global_clk);
    check("valid_n3", 32'(ins_valid), 32'd1);
    check("word_n3", 32'(ins_word), 32'h8123);
    run_to_halt("basic", 100);

    // HLT-encoded immediates after LDI and STI must not stop fetching
    do_reset();
    mem[0] = 16'h1234; mem[1] = 16'hE000; mem[2] = 16'h8001; mem[3] = 16'h2005;
    mem[4] = 16'hE000; mem[5] = 16'h3456; mem[6] = 16'hE000;
    build_exp(8'h00);
    ready_mode = 1; ack_pct = 70;
    pulse_start(8'h00);
    run_to_halt("imm_hlt", 300);

    // Execute stall: FIFO fills, requests stop, output held
    do_reset();
    gen_prog(8'h10, 12);
    build_exp(8'h10);
    exp_acks = QDEPTH + (exp_q[0].has ? 2 : 1);
    ready_mode = 2; ack_pct = 100; acks = 0;
    pulse_start(8'h10);
    snap_ok = 1'b0; diffs = 0;
    s_word = 16'h0; s_imm = 16'h0; s_has = 1'b0; s_pc = 8'h0;
    repeat (20) begin
      @(negedge Global_clk);
      if (snap_ok) begin
        if ((ins_word !== s_word) || (ins_imm !== s_imm) || (ins_has_imm !== s_has) ||
            (ins_pc !== s_pc) || (ins_valid !== 1'b1)) diffs++;
      end else if (ins_valid) begin
        snap_ok = 1'b1;
        s_word = ins_word; s_imm = ins_imm; s_has = ins_has_imm; s_pc = ins_pc;
      end
    end
    check("stall_valid", 32'(ins_valid), 32'd1);
    check("stall_stable", 32'(diffs), 32'd0);
    check("stall_req_low", 32'(mem_req), 32'd0);
    check("stall_acks", 32'(acks), 32'(exp_acks));
    ready_mode = 1; ack_pct = 50;
    run_to_halt("stall", 600);

    // Flush coinciding with an ack: word dropped, refetch from 0x40
    do_reset();
    gen_prog(8'h00, 15);
    gen_prog(8'h40, 5);
    build_exp(8'h00);
    flush_pc = 8'h40;
    ready_mode = 1; ack_pct = 60;
    pulse_start(8'h00);
    repeat (6) @(negedge Global_clk);
    flush_pend = 1'b1;
    k = 0;
    while (flush_pend && (k < 100)) begin
      @(negedge Global_clk);
      k++;
    end
    check("flush_issued", 32'(flush_pend), 32'd0);
    flush_pend = 1'b0;
    run_to_halt("flush", 400);

    // PC wrap: instruction at the top address, immediate at address 0
    do_reset();
    mem[8'hFF] = 16'h9ABC; mem[0] = 16'h1357; mem[1] = 16'hE000;
    build_exp(8'hFF);
    ready_mode = 0; ack_pct = 100;
    pulse_start(8'hFF);
    run_to_halt("wrap", 100);

    // Random programs, start addresses, ready and ack timing
    for (int it = 0; it < 5; it++) begin
      logic [7:0] sp;
      do_reset();
      sp = 8'($urandom);
      gen_prog(sp, int'($urandom_range(20, 3)));
      build_exp(sp);
      ready_mode = 1;
      ack_pct = int'($urandom_range(100, 30));
      pulse_start(sp);
      run_to_halt("random", 1500);
    end

    // Reset asserted while requesting and presenting an instruction
    do_reset();
    gen_prog(8'h80, 20);
    build_exp(8'h80);
    ready_mode = 1; ack_pct = 50;
    pulse_start(8'h80);
    k = 0;
    while (!(mem_req && ins_valid) && (k < 200)) begin
      @(negedge Global_clk);
      k++;
    end
    check("busy_before_reset", 32'(mem_req & ins_valid), 32'd1);
    Global_rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge Global_clk);
    Global_rst_n = 1'b1;
    exp_q.delete();
    extra_ins = 0;
    diffs = 0;
    repeat (10) begin
      @(negedge Global_clk);
      if (mem_req || ins_valid) diffs++;
    end
    check("quiet_after_reset", 32'(diffs), 32'd0);
    check("quiet_extra", 32'(extra_ins), 32'd0);
    build_exp(8'h80);
    pulse_start(8'h80);
    run_to_halt("restart", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
